// File: rtl/lsu_mem_resp_pkg.sv
// lsu_mem_resp_pkg: FSM state encoding, one-hot access sizes, base byte masks
// and small request-classification helpers shared by the load/store responder.
package lsu_mem_resp_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC1 = 3'd1,
    S_ACC2 = 3'd2,
    S_CAP1 = 3'd3,
    S_CAP  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  localparam logic [2:0] LEN_B = 3'b001;
  localparam logic [2:0] LEN_H = 3'b010;
  localparam logic [2:0] LEN_W = 3'b100;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Only the three one-hot encodings are meaningful access sizes.
  function automatic logic len_legal(input logic [2:0] len);
    return (len == LEN_B) || (len == LEN_H) || (len == LEN_W);
  endfunction

  // An access crosses a word boundary when its bytes do not fit in one RAM word.
  function automatic logic is_split(input logic [2:0] len, input logic [1:0] off);
    return ((len == LEN_H) && (off == 2'd3)) || ((len == LEN_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering. Positions store data and
// byte enables across a pair of RAM words, and extracts/extends load data
// from a pair of read words.
module lsu_lane_align
  import lsu_mem_resp_pkg::*;
(
  input  logic [2:0]  len,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [31:0] wdata,
  output logic [3:0]  st_mask0,
  output logic [3:0]  st_mask1,
  output logic [31:0] st_data0,
  output logic [31:0] st_data1,
  output logic [31:0] ld_data
);

  logic [3:0]  base_mask;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic [63:0] shifted;
  logic        unused_ld_hi;

  // Shift the store data/mask by the byte offset and split them over two words.
  always_comb begin
    base_mask = 4'b0000;
    case (len)
      LEN_B:   base_mask = MASK_B;
      LEN_H:   base_mask = MASK_H;
      LEN_W:   base_mask = MASK_W;
      default: base_mask = 4'b0000;
    endcase
    mask8    = {4'b0000, base_mask} << off;
    data64   = {32'b0, wdata} << {off, 3'b000};
    st_mask0 = mask8[3:0];
    st_mask1 = mask8[7:4];
    st_data0 = data64[31:0];
    st_data1 = data64[63:32];
  end

  // Right-align the loaded bytes, then sign- or zero-extend sub-word sizes.
  always_comb begin
    shifted = {word1, word0} >> {off, 3'b000};
    ld_data = shifted[31:0];
    case (len)
      LEN_B:   ld_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      LEN_H:   ld_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted[31:0];
    endcase
  end

  assign unused_ld_hi = ^shifted[63:32];

endmodule

// File: rtl/lsu_mem_resp.sv
// lsu_mem_resp: single-outstanding load/store responder in front of a
// synchronous single-port 32-bit data RAM.
// Build option LSU_MISALIGN_SPLIT_EN: when defined, word-crossing accesses are
// performed as two RAM accesses; when undefined they are answered with an error.
module lsu_mem_resp
  import lsu_mem_resp_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [2:0]    req_len,
  input  logic          req_signed,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  state_t        state, state_nxt;
  logic          accept;
  logic          req_split;
  logic          req_bad;
  logic          we_q;
  logic [2:0]    len_q;
  logic          signed_q;
  logic [1:0]    off_q;
  logic [AW-1:0] word0_q;
  logic [31:0]   wdata_q;
  logic [31:0]   result_q;
  logic          err_q;
  logic [3:0]    st_mask0, st_mask1;
  logic [31:0]   st_data0, st_data1;
  logic [31:0]   ld_word0, ld_word1;
  logic [31:0]   ld_data;
  logic          unused_addr_hi;

  assign accept    = req_valid & (state == S_IDLE);
  assign req_split = is_split(req_len, req_addr[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic          split_q;
  logic [31:0]   rdata0_q;
  logic [AW-1:0] word1;

  assign req_bad  = ~len_legal(req_len);
  assign word1    = word0_q + AW'(1);
  assign ld_word0 = split_q ? rdata0_q : ram_rdata;
  assign ld_word1 = split_q ? ram_rdata : 32'b0;
`else
  logic unused_st_hi;

  assign req_bad      = ~len_legal(req_len) | req_split;
  assign ld_word0     = ram_rdata;
  assign ld_word1     = 32'b0;
  assign unused_st_hi = ^{st_mask1, st_data1};
`endif

  assign unused_addr_hi = ^req_addr[31:AW+2];
  assign resp_rdata     = result_q;
  assign resp_err       = err_q;

  lsu_lane_align u_align (
    .len      (len_q),
    .off      (off_q),
    .sign_ext (signed_q),
    .word0    (ld_word0),
    .word1    (ld_word1),
    .wdata    (wdata_q),
    .st_mask0 (st_mask0),
    .st_mask1 (st_mask1),
    .st_data0 (st_data0),
    .st_data1 (st_data1),
    .ld_data  (ld_data)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and RAM/handshake outputs; RAM pins are zero unless accessing.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 4'b0000;
    ram_addr   = '0;
    ram_wdata  = 32'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_bad ? S_RESP : S_ACC1;
      end
      S_ACC1: begin
        ram_en   = 1'b1;
        ram_addr = word0_q;
        if (we_q) begin
          ram_we    = st_mask0;
          ram_wdata = st_data0;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_q) state_nxt = we_q ? S_ACC2 : S_CAP1;
        else         state_nxt = we_q ? S_RESP : S_CAP;
`else
        state_nxt = we_q ? S_RESP : S_CAP;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_CAP1: begin
        ram_en    = 1'b1;
        ram_addr  = word1;
        state_nxt = S_CAP;
      end
      S_ACC2: begin
        ram_en    = 1'b1;
        ram_addr  = word1;
        ram_we    = st_mask1;
        ram_wdata = st_data1;
        state_nxt = S_RESP;
      end
`endif
      S_CAP: state_nxt = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the accepted request and build the response payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      len_q    <= 3'b000;
      signed_q <= 1'b0;
      off_q    <= 2'b00;
      word0_q  <= '0;
      wdata_q  <= 32'b0;
      result_q <= 32'b0;
      err_q    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q  <= 1'b0;
      rdata0_q <= 32'b0;
`endif
    end else begin
      if (accept) begin
        we_q     <= req_we;
        len_q    <= req_len;
        signed_q <= req_signed;
        off_q    <= req_addr[1:0];
        word0_q  <= req_addr[AW+1:2];
        wdata_q  <= req_wdata;
        result_q <= 32'b0;
        err_q    <= req_bad;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_q  <= req_split;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state == S_CAP1) rdata0_q <= ram_rdata;
`endif
      if (state == S_CAP) result_q <= ld_data;
    end
  end

endmodule

// File: tb/tb_lsu_mem_resp.sv
// tb_lsu_mem_resp: randomized scoreboard bench for lsu_mem_resp. A byte-level
// memory model predicts every response; a monitor checks data, error flag,
// latency, RAM access count and response stability.
module tb_lsu_mem_resp;

  localparam int AW     = 12;
  localparam int DEPTH  = 1 << AW;
  localparam int NBYTES = 4 * DEPTH;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nacc;
    int          acc_cyc;
    int          ram_snap;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [31:0]   req_addr, req_wdata;
  logic [2:0]    req_len;
  logic          resp_valid, resp_ready, resp_err;
  logic [31:0]   resp_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  logic [31:0] mem [DEPTH];
  bit          mem_init_done = 1'b0;
  logic [7:0]  ref_mem [NBYTES];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          ram_cycles = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          hold_ready = 1'b0;

  always #5 clk = ~clk;

  lsu_mem_resp #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_len    (req_len),
    .req_signed (req_signed),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // Synchronous byte-enabled RAM; preloaded with a known pattern at the first edge.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      ram_rdata     <= 32'b0;
      mem_init_done <= 1'b1;
    end else if (ram_en) begin
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      else
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
  endtask

  // Reference model: byte-addressed memory, sizes from the one-hot length.
  task automatic modelRequest(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] len, input logic sgn, output exp_t e);
    int size, base;
    bit split;
    logic [31:0] v;
    size  = (len == 3'b001) ? 1 : (len == 3'b010) ? 2 : (len == 3'b100) ? 4 : 0;
    base  = int'(addr[AW+1:0]);
    split = (size != 0) && ((base % 4) + size > 4);
    e.rdata = 32'b0; e.err = 1'b0; e.lat = 1; e.nacc = 0; e.acc_cyc = 0; e.ram_snap = 0;
    if (size == 0 || (split && !SPLIT_EN)) begin
      e.err = 1'b1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[(base + i) % NBYTES] = wdata[8*i +: 8];
      e.lat  = split ? 3 : 2;
      e.nacc = split ? 2 : 1;
    end else begin
      v = 32'b0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[(base + i) % NBYTES];
      if (sgn && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      e.rdata = v;
      e.lat   = split ? 4 : 3;
      e.nacc  = split ? 2 : 1;
    end
  endtask

  // Present one request, hold it until accepted, and record the prediction.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] len, input logic sgn);
    exp_t e;
    int waited;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_len = len; req_signed = sgn;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_ready && waited < 200);
    checkOutput("req_accept", 32'(req_ready), 32'd1);
    if (req_ready) begin
      modelRequest(we, addr, wdata, len, sgn, e);
      e.acc_cyc  = cyc;
      e.ram_snap = ram_cycles;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 300 && !(req_ready && exp_q.size() == 0); i++) @(negedge clk);
    checkOutput("idle_wait_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Random response backpressure unless a directed test freezes it.
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      resp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare every presented response with the oldest prediction.
  initial begin
    exp_t cur;
    bit seen_valid;
    logic [31:0] cap_rdata;
    logic cap_err;
    seen_valid = 1'b0; cap_rdata = 32'b0; cap_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen_valid = 1'b0;
        exp_q.delete();
      end else begin
        if (ram_en) ram_cycles++;
        if (resp_valid) begin
          if (!seen_valid) begin
            seen_valid = 1'b1;
            cap_rdata  = resp_rdata;
            cap_err    = resp_err;
            checkOutput("resp_has_request", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) checkOutput("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(exp_q[0].lat));
          end else begin
            checkOutput("hold_rdata", resp_rdata, cap_rdata);
            checkOutput("hold_err", 32'(resp_err), 32'(cap_err));
          end
          checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
          if (resp_ready) begin
            seen_valid = 1'b0;
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              checkOutput("resp_rdata", resp_rdata, cur.rdata);
              checkOutput("resp_err", 32'(resp_err), 32'(cur.err));
              checkOutput("ram_accesses", 32'(ram_cycles - cur.ram_snap), 32'(cur.nacc));
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [2:0]  len;
    logic [31:0] addr;
    int          word;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'b0;
    req_wdata = 32'b0; req_len = 3'b000; req_signed = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = init_word(i) >> (8*b);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_ram_en", 32'(ram_en), 32'd0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 3'b100, 1'b0);
    @(negedge clk);
    checkOutput("sw_ram_en", 32'(ram_en), 32'd1);
    checkOutput("sw_ram_we", 32'(ram_we), 32'hF);
    checkOutput("sw_ram_addr", 32'(ram_addr), 32'd4);
    checkOutput("sw_ram_wdata", ram_wdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b100, 1'b0);

    applyStimulus(1'b1, 32'h10, 32'h80FF7F01, 3'b100, 1'b0);
    applyStimulus(1'b0, 32'h13, 32'h0, 3'b001, 1'b1);
    applyStimulus(1'b0, 32'h13, 32'h0, 3'b001, 1'b0);
    applyStimulus(1'b0, 32'h11, 32'h0, 3'b001, 1'b1);

    applyStimulus(1'b1, 32'h12, 32'h0000ABCD, 3'b010, 1'b0);
    @(negedge clk);
    checkOutput("sh_ram_we", 32'(ram_we), 32'hC);
    checkOutput("sh_wdata_hi", 32'(ram_wdata[31:16]), 32'hABCD);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b100, 1'b0);

    applyStimulus(1'b1, 32'h10, 32'hAA000000, 3'b100, 1'b0);
    applyStimulus(1'b1, 32'h14, 32'h00332211, 3'b100, 1'b0);
    applyStimulus(1'b0, 32'h13, 32'h0, 3'b100, 1'b0);
    applyStimulus(1'b0, 32'h12, 32'h0, 3'b010, 1'b1);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b011, 1'b0);

    // Hold off the response for several cycles.
    waitIdle();
    hold_ready = 1'b1;
    applyStimulus(1'b0, 32'h11, 32'h0, 3'b010, 1'b1);
    for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
    checkOutput("bp_valid_seen", 32'(resp_valid), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("bp_valid_held", 32'(resp_valid), 32'd1);
    checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
    hold_ready = 1'b0;

    // Reset while the load is capturing its data.
    waitIdle();
    hold_ready = 1'b1;
    applyStimulus(1'b0, 32'h20, 32'h0, 3'b100, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("midrst_ram_en", 32'(ram_en), 32'd0);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    hold_ready = 1'b0;

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: len = 3'b001;
        3, 4, 5: len = 3'b010;
        6, 7, 8: len = 3'b100;
        default: begin
          do len = 3'($urandom_range(0, 7));
          while (len == 3'b001 || len == 3'b010 || len == 3'b100);
        end
      endcase
      word = ($urandom_range(0, 15) == 0) ? DEPTH - 1 : int'($urandom_range(0, 15));
      addr = ($urandom & ~32'((1 << (AW + 2)) - 1)) | (32'(word) << 2) | 32'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, len, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
